tk1_spi_flash_reader: RTL and testbench

//  Read-sequencer upstream of the tk1 byte-level SPI master. On a host command it asserts flash

---
 rtl/tk1_spi_flash_pkg.sv | 44 ++++
 rtl/tk1_spi_flash_fifo.sv | 56 +++++
 rtl/tk1_spi_flash_reader.sv | 165 ++++++++++++++++
 tb/tb_tk1_spi_flash_reader.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tk1_spi_flash_pkg.sv
// Shared definitions for the tk1 SPI flash read sequencer: opcodes, header
// length, FSM state encoding and the header byte selector.
// Build option: TK1_SPI_FLASH_FAST_READ_EN selects FAST_READ (0x0B) with one
// dummy byte after the address; otherwise plain READ (0x03).
package tk1_spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

`ifdef TK1_SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OP_CODE   = OP_FAST_READ;
  localparam int         HDR_LEN   = 5;
  localparam int         HDR_CTR_W = 3;
`else
  localparam logic [7:0] OP_CODE   = OP_READ;
  localparam int         HDR_LEN   = 4;
  localparam int         HDR_CTR_W = 2;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_ON,
    ST_SEND,
    ST_GUARD,
    ST_WAIT,
    ST_CS_OFF,
    ST_DONE
  } state_t;

  // Header byte for position idx: opcode, address MSB first, then dummy 0x00.
  function automatic logic [7:0] hdr_byte(input logic [23:0]          addr,
                                          input logic [HDR_CTR_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      HDR_CTR_W'(0): b = OP_CODE;
      HDR_CTR_W'(1): b = addr[23:16];
      HDR_CTR_W'(2): b = addr[15:8];
      HDR_CTR_W'(3): b = addr[7:0];
      default:       b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tk1_spi_flash_fifo.sv
// Synchronous read-data FIFO, DEPTH x 8. Push while full is accepted only
// when a pop happens in the same cycle; pop on empty is ignored. The head
// byte reads as zero while empty so the output is defined after reset.
module tk1_spi_flash_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] data
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign data    = empty ? 8'h00 : mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; the occupancy count alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tk1_spi_flash_reader.sv
// tk1 SPI flash read sequencer. On cmd_start it selects the flash, sends the
// read header and LEN dummy bytes through the byte-level SPI master, and
// queues every received data byte in a FIFO drained over rd_vld/rd_rdy.
// Build option: TK1_SPI_FLASH_FAST_READ_EN (see tk1_spi_flash_pkg).
module tk1_spi_flash_reader
  import tk1_spi_flash_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_start,
  input  logic [23:0]          cmd_addr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 cmd_abort,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           rd_data,
  output logic                 rd_vld,
  input  logic                 rd_rdy,
  output logic                 spi_enable,
  output logic                 spi_enable_vld,
  output logic                 spi_start,
  output logic [7:0]           spi_tx_data,
  output logic                 spi_tx_data_vld,
  input  logic [7:0]           spi_rx_data,
  input  logic                 spi_ready
);

  state_t               state;
  logic [23:0]          addr_q;
  logic [LEN_WIDTH-1:0] remaining;
  logic [HDR_CTR_W-1:0] hdr_ctr;
  logic                 in_hdr;
  logic                 abort_pend;
  logic                 last_hdr;
  logic                 fifo_push;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign last_hdr  = (hdr_ctr == HDR_CTR_W'(HDR_LEN - 1));
  // A data byte is kept only if it completes with no abort pending or arriving.
  assign fifo_push = (state == ST_WAIT) && spi_ready && !in_hdr && !abort_pend && !cmd_abort;
  assign rd_vld    = !fifo_empty;

  tk1_spi_flash_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (spi_rx_data),
    .pop       (rd_rdy),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .data      (rd_data)
  );

  // Transfer sequencer: chip select, header, data bytes, deselect, done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      addr_q          <= '0;
      remaining       <= '0;
      hdr_ctr         <= '0;
      in_hdr          <= 1'b0;
      abort_pend      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      spi_enable      <= 1'b0;
      spi_enable_vld  <= 1'b0;
      spi_start       <= 1'b0;
      spi_tx_data     <= '0;
      spi_tx_data_vld <= 1'b0;
    end else begin
      // NOTE: strobes default low here so each one lasts exactly one clock.
      spi_enable_vld  <= 1'b0;
      spi_start       <= 1'b0;
      spi_tx_data_vld <= 1'b0;
      done            <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_start && !busy) begin
            busy       <= 1'b1;
            addr_q     <= cmd_addr;
            remaining  <= cmd_len;
            hdr_ctr    <= '0;
            in_hdr     <= 1'b1;
            abort_pend <= 1'b0;
            if (cmd_len == '0) begin
              state <= ST_DONE;
            end else begin
              state          <= ST_CS_ON;
              spi_enable     <= 1'b1;
              spi_enable_vld <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_CS_ON: begin
          if (cmd_abort) begin
            state          <= ST_CS_OFF;
            spi_enable     <= 1'b0;
            spi_enable_vld <= 1'b1;
          end else begin
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (cmd_abort) begin
            state          <= ST_CS_OFF;
            spi_enable     <= 1'b0;
            spi_enable_vld <= 1'b1;
          end else if (spi_ready && (in_hdr || !fifo_full)) begin
            spi_start       <= 1'b1;
            spi_tx_data_vld <= 1'b1;
            spi_tx_data     <= in_hdr ? hdr_byte(addr_q, hdr_ctr) : 8'h00;
            state           <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          // The master still shows ready this cycle; only remember an abort.
          if (cmd_abort) abort_pend <= 1'b1;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (spi_ready) begin
            if (abort_pend || cmd_abort) begin
              state          <= ST_CS_OFF;
              spi_enable     <= 1'b0;
              spi_enable_vld <= 1'b1;
            end else if (in_hdr) begin
              hdr_ctr <= hdr_ctr + 1'b1;
              if (last_hdr) in_hdr <= 1'b0;
              state <= ST_SEND;
            end else begin
              if (remaining != '0) remaining <= remaining - 1'b1;
              if (remaining <= LEN_WIDTH'(1)) begin
                state          <= ST_CS_OFF;
                spi_enable     <= 1'b0;
                spi_enable_vld <= 1'b1;
              end else begin
                state <= ST_SEND;
              end
            end
          end else if (cmd_abort) begin
            abort_pend <= 1'b1;
          end
        end
        ST_CS_OFF: begin
          abort_pend <= 1'b0;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tk1_spi_flash_reader.sv
// Self-checking bench for tk1_spi_flash_reader: a behavioural byte-level SPI
// master plus flash image answer each exchange; expected MOSI bytes and read
// data are queued per command and checked by one compare process.
// Build option honoured: TK1_SPI_FLASH_FAST_READ_EN.
module tb_tk1_spi_flash_reader;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_WIDTH  = 16;
  localparam int BYTE_T     = 6;
`ifdef TK1_SPI_FLASH_FAST_READ_EN
  localparam int         HDR = 5;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int         HDR = 4;
  localparam logic [7:0] OPC = 8'h03;
`endif

  logic                 clk;
  logic                 reset_n;
  logic                 cmd_start;
  logic [23:0]          cmd_addr;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic                 cmd_abort;
  logic                 busy;
  logic                 done;
  logic [7:0]           rd_data;
  logic                 rd_vld;
  logic                 rd_rdy;
  logic                 spi_enable;
  logic                 spi_enable_vld;
  logic                 spi_start;
  logic [7:0]           spi_tx_data;
  logic                 spi_tx_data_vld;
  logic [7:0]           spi_rx_data;
  logic                 spi_ready;

  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;
  int vld_cnt   = 0;
  int done_cnt  = 0;
  int pop_cnt   = 0;

  logic [7:0] exp_mosi [$];
  logic [7:0] exp_rd   [$];

  always #5 clk = ~clk;

  tk1_spi_flash_reader #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_start       (cmd_start),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .cmd_abort       (cmd_abort),
    .busy            (busy),
    .done            (done),
    .rd_data         (rd_data),
    .rd_vld          (rd_vld),
    .rd_rdy          (rd_rdy),
    .spi_enable      (spi_enable),
    .spi_enable_vld  (spi_enable_vld),
    .spi_start       (spi_start),
    .spi_tx_data     (spi_tx_data),
    .spi_tx_data_vld (spi_tx_data_vld),
    .spi_rx_data     (spi_rx_data),
    .spi_ready       (spi_ready)
  );

  // Flash image: three pinned bytes, everything else a fixed address hash.
  function automatic logic [7:0] fmem_get(input logic [23:0] a);
    case (a)
      24'h012345: return 8'hAA;
      24'h012346: return 8'hBB;
      24'h012347: return 8'hCC;
      default:    return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'h3C;
    endcase
  endfunction

  // Byte-level SPI master + flash: ready drops after a start, returns BYTE_T clocks later.
  logic        m_busy;
  logic        m_ready;
  logic [7:0]  m_rx;
  int          m_ctr;
  logic        ss_low;
  int          sess_idx;
  logic [23:0] sess_addr;

  assign spi_ready   = m_ready;
  assign spi_rx_data = m_rx;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy    <= 1'b0;
      m_ready   <= 1'b1;
      m_rx      <= 8'h00;
      m_ctr     <= 0;
      ss_low    <= 1'b0;
      sess_idx  <= 0;
      sess_addr <= '0;
    end else begin
      if (spi_enable_vld) begin
        ss_low   <= spi_enable;
        sess_idx <= 0;
      end
      if (spi_start && !m_busy) begin
        m_busy   <= 1'b1;
        m_ready  <= 1'b0;
        m_ctr    <= BYTE_T;
        sess_idx <= sess_idx + 1;
        if (sess_idx >= HDR) m_rx <= fmem_get(sess_addr + 24'(sess_idx - HDR));
        else                 m_rx <= 8'hFF;
        if (sess_idx >= 1 && sess_idx <= 3) sess_addr <= {sess_addr[15:0], spi_tx_data};
      end else if (m_busy) begin
        if (m_ctr == 1) begin
          m_busy  <= 1'b0;
          m_ready <= 1'b1;
        end
        m_ctr <= m_ctr - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected traffic for one read: header, n_mosi dummy bytes, first n_rd image bytes.
  task automatic expect_xfer(input logic [23:0] a, input int n_mosi, input int n_rd);
    exp_mosi.push_back(OPC);
    exp_mosi.push_back(a[23:16]);
    exp_mosi.push_back(a[15:8]);
    exp_mosi.push_back(a[7:0]);
    if (HDR == 5) exp_mosi.push_back(8'h00);
    for (int i = 0; i < n_mosi; i++) exp_mosi.push_back(8'h00);
    for (int i = 0; i < n_rd; i++) exp_rd.push_back(fmem_get(a + 24'(i)));
  endtask

  // Compare process: every start byte and every popped read byte.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (done) done_cnt++;
        if (spi_enable_vld) vld_cnt++;
        if (spi_start) begin
          start_cnt++;
          check("tx_vld_with_start", 32'(spi_tx_data_vld), 1);
          check("ss_low_at_start", 32'(ss_low), 1);
          if (exp_mosi.size() == 0) check("mosi_queue_nonempty", exp_mosi.size(), 1);
          else check("mosi_byte", 32'(spi_tx_data), 32'(exp_mosi.pop_front()));
        end
        if (rd_vld && rd_rdy) begin
          pop_cnt++;
          if (exp_rd.size() == 0) check("rd_queue_nonempty", exp_rd.size(), 1);
          else check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [23:0] a, input logic [15:0] l);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  // Cycles counted from the edge that sampled cmd_start until done is seen.
  task automatic wait_done(input string tag, input int limit, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < limit) begin
      @(negedge clk);
      cyc++;
      got = done;
    end
    if (!got) check({tag, "_done_timeout"}, 32'(got), 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s0, d0, v0, p0, n;
    clk = 1'b0; reset_n = 1'b0; cmd_start = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_abort = 1'b0; rd_rdy = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_vld", 32'(rd_vld), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_spi_enable", 32'(spi_enable), 0);
    check("rst_spi_enable_vld", 32'(spi_enable_vld), 0);
    check("rst_spi_start", 32'(spi_start), 0);
    check("rst_spi_tx_data_vld", 32'(spi_tx_data_vld), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Test 1: basic read of AA BB CC from 0x012345
    rd_rdy = 1'b1;
`ifdef TK1_SPI_FLASH_FAST_READ_EN
    expect_xfer(24'h012345, 3, 0);
`else
    exp_mosi.push_back(8'h03); exp_mosi.push_back(8'h01); exp_mosi.push_back(8'h23);
    exp_mosi.push_back(8'h45); exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h00);
    exp_mosi.push_back(8'h00);
`endif
    exp_rd.push_back(8'hAA); exp_rd.push_back(8'hBB); exp_rd.push_back(8'hCC);
    d0 = done_cnt; v0 = vld_cnt; p0 = pop_cnt;
    start_cmd(24'h012345, 16'd3);
    wait_done("t1", 2000, lat);
    tick();
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_enable_strobes", vld_cnt - v0, 2);
    check("t1_ss_high", 32'(ss_low), 0);
    check("t1_pops", pop_cnt - p0, 3);
    check("t1_mosi_left", exp_mosi.size(), 0);
    check("t1_busy_low", 32'(busy), 0);

    // Test 2: zero length finishes without touching chip select
    d0 = done_cnt; v0 = vld_cnt;
    start_cmd(24'h000000, 16'd0);
    wait_done("t2", 50, lat);
    check("t2_latency", lat, 2);
    tick();
    check("t2_no_enable", vld_cnt - v0, 0);
    check("t2_done_pulses", done_cnt - d0, 1);
    check("t2_fifo_empty", 32'(rd_vld), 0);

    // Test 3: back-pressure with len 8 into a 4-deep FIFO
    rd_rdy = 1'b0;
    expect_xfer(24'h004000, 8, 8);
    s0 = start_cnt; p0 = pop_cnt;
    start_cmd(24'h004000, 16'd8);
    repeat (150) tick();
    check("t3_starts_stalled", start_cnt - s0, HDR + 4);
    check("t3_busy", 32'(busy), 1);
    check("t3_sck_idle", 32'(m_busy), 0);
    check("t3_rd_vld", 32'(rd_vld), 1);
    repeat (40) tick();
    check("t3_still_stalled", start_cnt - s0, HDR + 4);
    rd_rdy = 1'b1;
    wait_done("t3", 2000, lat);
    tick();
    check("t3_pops", pop_cnt - p0, 8);
    check("t3_rd_left", exp_rd.size(), 0);
    check("t3_mosi_left", exp_mosi.size(), 0);

    // Test 4: abort during the second data byte of a 16-byte read
    rd_rdy = 1'b0;
    expect_xfer(24'h020000, 2, 1);
    s0 = start_cnt; d0 = done_cnt; p0 = pop_cnt;
    start_cmd(24'h020000, 16'd16);
    n = 0;
    while (start_cnt - s0 < HDR + 2 && n < 500) begin
      tick();
      n++;
    end
    check("t4_reached_2nd_data", start_cnt - s0, HDR + 2);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    wait_done("t4", 500, lat);
    tick();
    check("t4_starts", start_cnt - s0, HDR + 2);
    check("t4_ss_high", 32'(ss_low), 0);
    check("t4_done_pulses", done_cnt - d0, 1);
    check("t4_one_byte", 32'(rd_vld), 1);
    rd_rdy = 1'b1;
    repeat (2) tick();
    rd_rdy = 1'b0;
    check("t4_pops", pop_cnt - p0, 1);
    check("t4_fifo_empty", 32'(rd_vld), 0);
    check("t4_rd_left", exp_rd.size(), 0);

    // Test 5: cmd_start while busy is ignored
    rd_rdy = 1'b1;
    expect_xfer(24'h0A0B0C, 3, 3);
    s0 = start_cnt; d0 = done_cnt; v0 = vld_cnt;
    start_cmd(24'h0A0B0C, 16'd3);
    repeat (3) tick();
    start_cmd(24'hFFFFFF, 16'd5);
    wait_done("t5", 2000, lat);
    tick();
    repeat (20) tick();
    check("t5_starts", start_cnt - s0, HDR + 3);
    check("t5_done_pulses", done_cnt - d0, 1);
    check("t5_enable_strobes", vld_cnt - v0, 2);
    check("t5_busy_low", 32'(busy), 0);
    check("t5_rd_left", exp_rd.size(), 0);

    // Test 5b: start and abort together in IDLE -> start wins
    expect_xfer(24'h000010, 2, 2);
    p0 = pop_cnt;
    cmd_abort = 1'b1;
    start_cmd(24'h000010, 16'd2);
    cmd_abort = 1'b0;
    wait_done("t5b", 2000, lat);
    tick();
    check("t5b_pops", pop_cnt - p0, 2);
    check("t5b_mosi_left", exp_mosi.size(), 0);

`ifdef TK1_SPI_FLASH_FAST_READ_EN
    // Test 6: FAST_READ header
    exp_mosi.push_back(8'h0B); exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h01);
    exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h00);
    exp_mosi.push_back(8'h00);
    exp_rd.push_back(fmem_get(24'h000100)); exp_rd.push_back(fmem_get(24'h000101));
    p0 = pop_cnt;
    start_cmd(24'h000100, 16'd2);
    wait_done("t6", 2000, lat);
    tick();
    check("t6_pops", pop_cnt - p0, 2);
    check("t6_mosi_left", exp_mosi.size(), 0);
`endif

    // Reset in the middle of a transfer
    rd_rdy = 1'b0;
    expect_xfer(24'h030000, 4, 4);
    start_cmd(24'h030000, 16'd4);
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_spi_enable", 32'(spi_enable), 0);
    check("mid_rst_spi_start", 32'(spi_start), 0);
    check("mid_rst_rd_vld", 32'(rd_vld), 0);
    exp_mosi.delete();
    exp_rd.delete();
    tick();
    reset_n = 1'b1;
    tick();
    check("mid_rst_ss_high", 32'(ss_low), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
